// File: rtl/vga_timing_decoder.sv
// VGA sync decoder: recovers pixel position from active-low h/v sync,
// measures line/frame geometry, tracks lock against nominal timing and
// regenerates active-area coordinates with a data-enable.
module vga_timing_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       clr_err,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines
);

  localparam int unsigned CW = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0]    POS_MAX  = '1;
  localparam logic [9:0]    H_TOT_W  = 10'(H_TOTAL);
  localparam logic [9:0]    H_SYN_W  = 10'(H_SYNC);
  localparam logic [9:0]    V_TOT_W  = 10'(V_TOTAL);
  localparam logic [9:0]    V_SYN_W  = 10'(V_SYNC);
  localparam logic [9:0]    H_WIN_LO = 10'(H_ACT_START);
  localparam logic [9:0]    H_WIN_HI = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0]    V_WIN_LO = 10'(V_ACT_START);
  localparam logic [9:0]    V_WIN_HI = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_FRAMES);

  logic          hs_q, vs_q;
  logic [9:0]    h_pos, v_pos;
  logic          seen_h, seen_v;
  logic          v_in_sync;
  logic          frame_bad;
  logic [CW-1:0] good_cnt;

  logic          h_fall, h_rise, v_fall;
  logic [9:0]    h_plus, v_plus, h_inc, v_inc;
  logic          line_bad, h_width_bad, v_width_bad, sync_lost, frame_good, win;
  logic [CW-1:0] cnt_inc;

  // Edge detection, measurements and per-pixel error conditions
  always_comb begin
    h_fall      = pix_en & hs_q & ~h_sync;
    h_rise      = pix_en & ~hs_q & h_sync;
    v_fall      = h_fall & vs_q & ~v_sync;
    h_plus      = h_pos + 10'd1;
    v_plus      = v_pos + 10'd1;
    h_inc       = (h_pos == POS_MAX) ? POS_MAX : h_plus;
    v_inc       = (v_pos == POS_MAX) ? POS_MAX : v_plus;
    line_bad    = h_fall & seen_h & (h_plus != H_TOT_W);
    h_width_bad = h_rise & seen_h & (h_plus != H_SYN_W);
    // v_sync rise is only observed at a line start; width is lines since v_fall
    v_width_bad = h_fall & v_in_sync & v_sync & (v_plus != V_SYN_W);
    sync_lost   = pix_en & ~h_fall & (h_inc == POS_MAX);
    frame_good  = (v_plus == V_TOT_W) & ~frame_bad & ~line_bad;
    cnt_inc     = (good_cnt == CNT_MAX) ? good_cnt : good_cnt + CW'(1);
    win         = locked & (h_pos >= H_WIN_LO) & (h_pos < H_WIN_HI)
                         & (v_pos >= V_WIN_LO) & (v_pos < V_WIN_HI);
  end

  // Sync sampling, position counters and line/frame measurements
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      h_pos       <= '0;
      v_pos       <= '0;
      seen_h      <= 1'b0;
      seen_v      <= 1'b0;
      v_in_sync   <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else if (pix_en) begin
      hs_q <= h_sync;
      vs_q <= v_sync;
      if (h_fall) begin
        h_pos  <= '0;
        seen_h <= 1'b1;
        if (seen_h) line_len <= h_plus;
        if (v_fall) begin
          v_pos     <= '0;
          seen_v    <= 1'b1;
          v_in_sync <= 1'b1;
          if (seen_v) frame_lines <= v_plus;
        end else begin
          v_pos <= v_inc;
          if (v_sync) v_in_sync <= 1'b0;
        end
      end else begin
        h_pos <= h_inc;
        if (sync_lost) seen_h <= 1'b0;
      end
    end
  end

  // Lock tracking and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_cnt  <= '0;
      locked    <= 1'b0;
      frame_bad <= 1'b0;
      h_err     <= 1'b0;
      v_err     <= 1'b0;
    end else begin
      if (h_width_bad | line_bad) h_err <= 1'b1;
      else if (clr_err)           h_err <= 1'b0;
      if (v_width_bad)            v_err <= 1'b1;
      else if (clr_err)           v_err <= 1'b0;
      if (v_fall) begin
        frame_bad <= 1'b0;
        if (seen_v) begin
          if (frame_good) begin
            good_cnt <= cnt_inc;
            locked   <= (cnt_inc == CNT_MAX);
          end else begin
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end else if (line_bad) begin
          locked <= 1'b0;
        end
      end else if (pix_en) begin
        if (line_bad | h_width_bad | v_width_bad | sync_lost) frame_bad <= 1'b1;
        if (line_bad) locked <= 1'b0;
        if (sync_lost) begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

  // Active-window outputs, one pixel behind the position counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_fall;
      if (pix_en) begin
        de <= win;
        x  <= win ? h_pos - H_WIN_LO : '0;
        y  <= win ? v_pos - V_WIN_LO : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder using a reduced raster so that several
// frames fit in a short run; a behavioural model predicts every output.
module tb_vga_timing_decoder;

  localparam int HT  = 40;
  localparam int HSW = 6;
  localparam int HAS = 10;
  localparam int HA  = 24;
  localparam int VT  = 12;
  localparam int VSW = 2;
  localparam int VAS = 3;
  localparam int VA  = 8;
  localparam int LF  = 2;

  logic       clk = 1'b0;
  logic       reset, pix_en, h_sync, v_sync, clr_err;
  logic [9:0] x, y, line_len, frame_lines;
  logic       de, frame_start, locked, h_err, v_err;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  vga_timing_decoder #(
    .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_START(HAS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VSW), .V_ACT_START(VAS), .V_ACTIVE(VA),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(h_sync),
    .v_sync(v_sync), .clr_err(clr_err), .x(x), .y(y), .de(de),
    .frame_start(frame_start), .locked(locked), .h_err(h_err),
    .v_err(v_err), .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  // Model state: position since the last observed edges, plus the list of
  // line lengths measured in the current frame.
  int m_prev_hs, m_prev_vs, m_ph, m_pv, m_seen_h, m_seen_v, m_vopen, m_run, m_damaged;
  int m_lens[$];
  int m_x, m_y, m_de, m_fs, m_locked, m_herr, m_verr, m_ll, m_fl;
  int e_x, e_y, e_de, e_fs, e_locked, e_herr, e_verr, e_ll, e_fl;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_hs = 1; m_prev_vs = 1; m_ph = 0; m_pv = 0;
    m_seen_h = 0; m_seen_v = 0; m_vopen = 0; m_run = 0; m_damaged = 0;
    m_lens.delete();
    m_x = 0; m_y = 0; m_de = 0; m_fs = 0; m_locked = 0;
    m_herr = 0; m_verr = 0; m_ll = 0; m_fl = 0;
  endtask

  task automatic commit();
    e_x = m_x; e_y = m_y; e_de = m_de; e_fs = m_fs; e_locked = m_locked;
    e_herr = m_herr; e_verr = m_verr; e_ll = m_ll; e_fl = m_fl;
  endtask

  task automatic model_step(input bit pe, input bit hs, input bit vs, input bit clr);
    bit set_h = 0;
    bit set_v = 0;
    m_fs = 0;
    if (pe) begin
      bit fall  = (m_prev_hs == 1) && !hs;
      bit rise  = (m_prev_hs == 0) && hs;
      bit inwin = (m_locked == 1) && m_ph >= HAS && m_ph < HAS + HA
                                  && m_pv >= VAS && m_pv < VAS + VA;
      m_de = inwin;
      m_x  = inwin ? m_ph - HAS : 0;
      m_y  = inwin ? m_pv - VAS : 0;
      if (fall) begin
        if (m_seen_h == 1) begin
          m_ll = m_ph + 1;
          m_lens.push_back(m_ph + 1);
          if (m_ph + 1 != HT) begin set_h = 1; m_locked = 0; end
        end
        m_seen_h = 1;
        if (m_prev_vs == 1 && !vs) begin
          m_fs = 1;
          if (m_seen_v == 1) begin
            bit good = (m_pv + 1 == VT) && (m_damaged == 0);
            foreach (m_lens[i]) if (m_lens[i] != HT) good = 0;
            m_fl = m_pv + 1;
            if (good) begin
              if (m_run < LF) m_run++;
              m_locked = (m_run == LF);
            end else begin
              m_run = 0; m_locked = 0;
            end
          end
          m_lens.delete();
          m_damaged = 0; m_seen_v = 1; m_vopen = 1; m_pv = 0;
        end else begin
          if (m_vopen == 1 && vs) begin
            if (m_pv + 1 != VSW) begin set_v = 1; m_damaged = 1; end
            m_vopen = 0;
          end
          m_pv = (m_pv >= 1023) ? 1023 : m_pv + 1;
        end
        m_ph = 0;
      end else begin
        if (rise && m_seen_h == 1 && m_ph + 1 != HSW) begin set_h = 1; m_damaged = 1; end
        m_ph = (m_ph >= 1023) ? 1023 : m_ph + 1;
        if (m_ph == 1023) begin m_run = 0; m_locked = 0; m_seen_h = 0; m_damaged = 1; end
      end
      m_prev_hs = hs; m_prev_vs = vs;
    end
    m_herr = set_h ? 1 : (clr ? 0 : m_herr);
    m_verr = set_v ? 1 : (clr ? 0 : m_verr);
  endtask

  // Every-cycle comparison of the DUT against the model, away from the edge
  always @(negedge clk) begin
    if (cmp_on) begin
      check("x", int'(x), e_x);
      check("y", int'(y), e_y);
      check("de", int'(de), e_de);
      check("frame_start", int'(frame_start), e_fs);
      check("locked", int'(locked), e_locked);
      check("h_err", int'(h_err), e_herr);
      check("v_err", int'(v_err), e_verr);
      check("line_len", int'(line_len), e_ll);
      check("frame_lines", int'(frame_lines), e_fl);
    end
  end

  task automatic cyc(input bit pe, input bit hs, input bit vs, input bit clr);
    pix_en = pe; h_sync = hs; v_sync = vs; clr_err = clr;
    model_step(pe, hs, vs, clr);
    @(posedge clk); #1;
    commit();
  endtask

  task automatic pix(input bit hs, input bit vs);
    int g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) cyc(1'b0, h_sync, v_sync, 1'b0);
    cyc(1'b1, hs, vs, 1'b0);
  endtask

  task automatic line_part(input int len, input int hw, input bit vlow, input int p0, input int p1);
    for (int p = p0; p <= p1 && p < len; p++) pix(p >= hw, !vlow);
  endtask

  task automatic line(input int len, input int hw, input bit vlow);
    line_part(len, hw, vlow, 0, len - 1);
  endtask

  task automatic lines(input int l0, input int l1, input int vw);
    for (int l = l0; l < l1; l++) line(HT, HSW, l < vw);
  endtask

  task automatic frame(input int nl, input int vw);
    lines(0, nl, vw);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_h_err"}, int'(h_err), 0);
    check({tag, "_v_err"}, int'(v_err), 0);
    check({tag, "_line_len"}, int'(line_len), 0);
    check({tag, "_frame_lines"}, int'(frame_lines), 0);
  endtask

  task automatic do_reset();
    pix_en = 1'b0; clr_err = 1'b0;
    #2 reset = 1'b1;
    model_reset(); commit();
    #1 check_all_zero("midreset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic rand_frame();
    int nl = ($urandom_range(0, 4) == 0) ? VT - 1 + int'($urandom_range(0, 2)) : VT;
    int vw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : VSW;
    for (int l = 0; l < nl; l++) begin
      int len = ($urandom_range(0, 29) == 0) ? HT - 1 + int'($urandom_range(0, 2)) : HT;
      int hw  = ($urandom_range(0, 29) == 0) ? HSW - 1 + int'($urandom_range(0, 2)) : HSW;
      if ($urandom_range(0, 49) == 0) cyc(1'b0, h_sync, v_sync, 1'b1);
      line(len, hw, l < vw);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pix_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1; clr_err = 1'b0;
    model_reset(); commit();
    @(posedge clk); #1;
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    reset = 1'b0;

    // Two nominal frames: measured, not yet locked
    frame(VT, VSW); frame(VT, VSW);
    check("pre_lock_locked", int'(locked), 0);
    check("nominal_line_len", int'(line_len), HT);
    check("nominal_frame_lines", int'(frame_lines), VT);
    // Third v_fall: lock
    line_part(HT, HSW, 1, 0, 0);
    check("lock_at_3rd_vfall", int'(locked), 1);
    check("frame_start_pulse", int'(frame_start), 1);
    line_part(HT, HSW, 1, 1, HT - 1);
    lines(1, VT, VSW);

    // Active-window corners
    lines(0, VAS, VSW);
    line_part(HT, HSW, 0, 0, HAS + 1);
    check("first_px_de", int'(de), 1);
    check("first_px_x", int'(x), 0);
    check("first_px_y", int'(y), 0);
    line_part(HT, HSW, 0, HAS + 2, HT - 1);
    lines(VAS + 1, VAS + VA - 1, VSW);
    line_part(HT, HSW, 0, 0, HAS + HA);
    check("last_px_de", int'(de), 1);
    check("last_px_x", int'(x), HA - 1);
    check("last_px_y", int'(y), VA - 1);
    line_part(HT, HSW, 0, HAS + HA + 1, HAS + HA + 1);
    check("past_px_de", int'(de), 0);
    check("past_px_x", int'(x), 0);
    line_part(HT, HSW, 0, HAS + HA + 2, HT - 1);
    lines(VAS + VA, VT, VSW);

    // One short line
    lines(0, 5, VSW);
    line(HT - 1, HSW, 0);
    line_part(HT, HSW, 0, 0, 0);
    check("short_line_len", int'(line_len), HT - 1);
    check("short_line_locked", int'(locked), 0);
    check("short_line_h_err", int'(h_err), 1);
    line_part(HT, HSW, 0, 1, HT - 1);
    lines(7, VT, VSW);
    frame(VT, VSW); frame(VT, VSW);
    check("relock_pending", int'(locked), 0);
    line_part(HT, HSW, 1, 0, 0);
    check("relocked", int'(locked), 1);
    check("h_err_sticky", int'(h_err), 1);
    line_part(HT, HSW, 1, 1, HT - 1);
    lines(1, VT, VSW);
    cyc(1'b0, h_sync, v_sync, 1'b1);
    check("h_err_cleared", int'(h_err), 0);

    // Reset mid-frame while locked
    lines(0, 4, VSW);
    line_part(HT, HSW, 0, 0, 19);
    check("locked_before_reset", int'(locked), 1);
    do_reset();
    line_part(HT, HSW, 0, 20, HT - 1);
    line_part(HT, HSW, 0, 0, 0);
    check("first_fall_no_measure", int'(line_len), 0);
    line_part(HT, HSW, 0, 1, HT - 1);
    line_part(HT, HSW, 0, 0, 0);
    check("second_fall_measure", int'(line_len), HT);
    line_part(HT, HSW, 0, 1, HT - 1);
    lines(7, VT, VSW);

    // Narrow h_sync and an 11-line frame
    lines(0, 3, VSW);
    line(HT, HSW - 1, 0);
    check("narrow_hsync_h_err", int'(h_err), 1);
    lines(4, VT - 1, VSW);
    frame(VT, VSW);
    check("short_frame_lines", int'(frame_lines), VT - 1);
    check("short_frame_v_err", int'(v_err), 0);
    check("short_frame_locked", int'(locked), 0);

    // Relock, then lose sync on an overlong line
    frame(VT, VSW);
    lines(0, 4, VSW);
    check("locked_before_long", int'(locked), 1);
    line(1100, HSW, 0);
    line_part(HT - 3, HSW, 0, 0, 0);
    check("long_no_update", int'(line_len), HT);
    check("long_locked", int'(locked), 0);
    line_part(HT - 3, HSW, 0, 1, HT - 4);
    line_part(HT, HSW, 0, 0, 0);
    check("after_long_update", int'(line_len), HT - 3);
    line_part(HT, HSW, 0, 1, HT - 1);
    lines(7, VT, VSW);

    // Wide v_sync
    frame(VT, VSW + 1);
    check("wide_vsync_v_err", int'(v_err), 1);
    cyc(1'b0, h_sync, v_sync, 1'b1);
    check("v_err_cleared", int'(v_err), 0);

    for (int f = 0; f < 10; f++) rand_frame();
    frame(VT, VSW);
    repeat (4) cyc(1'b0, h_sync, v_sync, 1'b0);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
